// File: rtl/hrm_host_port.sv
// hrm_host_port: host ingress into the CPU INBOX, OUTBOX drain and framed component dumps on one egress stream
module hrm_host_port #(
    parameter int         FIFO_DEPTH = 32,
    parameter int         DMP_LAT    = 1,
    parameter logic [2:0] SEL_INBOX  = 3'd0,
    parameter logic [2:0] SEL_OUTBOX = 3'd1
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_h_data,
    input  logic       i_h_valid,
    output logic       o_h_ready,
    output logic [7:0] o_h_data,
    output logic [1:0] o_h_tag,
    output logic       o_h_last,
    output logic       o_h_valid,
    input  logic       i_h_ready,
    input  logic       i_cmd_dump,
    input  logic [2:0] i_cmd_sel,
    output logic       o_busy,
    output logic [7:0] o_cpu_in_data,
    output logic       o_cpu_in_wr,
    input  logic       i_cpu_in_full,
    output logic       o_cpu_out_rd,
    input  logic [7:0] i_cpu_out_data,
    input  logic       i_cpu_out_empty,
    output logic [2:0] o_cpu_dmp_chip_select,
    output logic [4:0] o_cpu_dmp_fifo_pos,
    input  logic [7:0] i_cpu_dmp_data,
    input  logic       i_cpu_dmp_valid
);
    typedef enum logic [1:0] {IDLE, DSET, DWAIT, DEMIT} state_t;
    state_t     state, state_n;
    logic [7:0] e_data, e_data_n, hd, hd_n, cnt, cnt_n;
    logic [1:0] e_tag, e_tag_n;
    logic       e_last, e_last_n, e_valid, e_valid_n, held, held_n, pop;
    logic [2:0] sel, sel_n;
    logic [4:0] pos, pos_n;
    logic       is_fifo, at_end;

    assign o_h_ready             = i_rst_n & ~i_cpu_in_full;
    assign o_cpu_in_wr           = o_h_ready & i_h_valid;
    assign o_cpu_in_data         = i_rst_n ? i_h_data : 8'h00;
    assign o_h_data              = e_data;
    assign o_h_tag               = e_tag;
    assign o_h_last              = e_last;
    assign o_h_valid             = e_valid;
    assign o_busy                = state != IDLE;
    assign o_cpu_out_rd          = pop;
    assign o_cpu_dmp_chip_select = sel;
    assign o_cpu_dmp_fifo_pos    = pos;
    assign is_fifo               = sel == SEL_INBOX || sel == SEL_OUTBOX;
    assign at_end                = pos == 5'(FIFO_DEPTH - 1);

    // held/hd carries the byte at pos-1 while pos is probed, so its last flag is known before release
    always_comb begin
        state_n = state;
        {e_data_n, e_tag_n, e_last_n} = {e_data, e_tag, e_last};
        e_valid_n = e_valid & ~i_h_ready;
        {hd_n, held_n, sel_n, pos_n, cnt_n} = {hd, held, sel, pos, cnt};
        pop = 1'b0;
        case (state)
            IDLE:
                if (i_cmd_dump && !e_valid) begin
                    {sel_n, pos_n, held_n} = {i_cmd_sel, 5'd0, 1'b0};
                    state_n = DSET;
                end else if (!i_cpu_out_empty && !e_valid) begin
                    pop = i_rst_n;
                    {e_data_n, e_tag_n, e_last_n, e_valid_n} = {i_cpu_out_data, 2'b00, 1'b0, 1'b1};
                end
            DSET: begin
                cnt_n = 8'(DMP_LAT);
                state_n = DWAIT;
            end
            DWAIT:
                if (cnt != 8'd0) cnt_n = cnt - 8'd1;
                else if (!is_fifo) begin
                    {e_data_n, e_tag_n, e_last_n, e_valid_n} = {i_cpu_dmp_data, 2'b01, 1'b1, 1'b1};
                    state_n = DEMIT;
                end else if (held) begin
                    {e_data_n, e_tag_n, e_last_n, e_valid_n} = {hd, 2'b01, ~i_cpu_dmp_valid, 1'b1};
                    {hd_n, held_n} = {i_cpu_dmp_data, i_cpu_dmp_valid};
                    state_n = DEMIT;
                end else if (i_cpu_dmp_valid && !at_end) begin
                    {hd_n, held_n, pos_n} = {i_cpu_dmp_data, 1'b1, pos + 5'd1};
                    state_n = DSET;
                end else if (i_cpu_dmp_valid || pos == 5'd0) begin
                    e_data_n = i_cpu_dmp_valid ? i_cpu_dmp_data : 8'h00;
                    e_tag_n = i_cpu_dmp_valid ? 2'b01 : 2'b10;
                    {e_last_n, e_valid_n} = 2'b11;
                    state_n = DEMIT;
                end else state_n = IDLE;
            DEMIT:
                if (!e_valid) begin
                    {e_data_n, e_tag_n, e_last_n, e_valid_n} = {hd, 2'b01, 1'b1, 1'b1};
                    held_n = 1'b0;
                end else if (i_h_ready) begin
                    if (e_last) state_n = IDLE;
                    else if (!at_end) begin
                        pos_n = pos + 5'd1;
                        state_n = DSET;
                    end
                end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state <= IDLE;
            {e_data, e_tag, e_last, e_valid} <= '0;
            {hd, held, sel, pos, cnt} <= '0;
        end else begin
            state <= state_n;
            {e_data, e_tag, e_last, e_valid} <= {e_data_n, e_tag_n, e_last_n, e_valid_n};
            {hd, held, sel, pos, cnt} <= {hd_n, held_n, sel_n, pos_n, cnt_n};
        end
endmodule

// File: doc/hrm_host_port.md
Name: hrm_host_port

Overview:
- Host-side endpoint for the HRM CPU's I/O boundary.
- Pushes a host byte stream into the CPU INBOX, honouring the INBOX full flag.
- Drains the CPU OUTBOX into a tagged host egress stream.
- On command, walks the CPU dump port and emits a component's contents as a framed burst on the same egress stream. Sits between the CPU top and a host transport (UART/SPI bridge).

Parameters:
- FIFO_DEPTH, 32, number of dump positions scanned for FIFO components (matches the 5-bit dump position).
- DMP_LAT, 1, settle cycles between driving a dump select/position and sampling the dump data/valid.
- SEL_INBOX, 3'd0, chip-select code of the INBOX.
- SEL_OUTBOX, 3'd1, chip-select code of the OUTBOX.

Ports:
- clk  in  1  single clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_h_data  in  8  host ingress byte.
- i_h_valid  in  1  ingress byte valid.
- o_h_ready  out  1  ingress accept.
- o_h_data  out  8  egress byte.
- o_h_tag  out  2  egress tag: 00 OUTBOX data, 01 dump data, 10 dump-empty marker.
- o_h_last  out  1  last byte of a dump frame; 0 for OUTBOX data.
- o_h_valid  out  1  egress byte valid.
- i_h_ready  in  1  egress accept.
- i_cmd_dump  in  1  single-cycle dump request.
- i_cmd_sel  in  3  component to dump.
- o_busy  out  1  dump in progress.
- o_cpu_in_data  out  8  to CPU INBOX data.
- o_cpu_in_wr  out  1  INBOX write strobe.
- i_cpu_in_full  in  1  INBOX full.
- o_cpu_out_rd  out  1  OUTBOX pop strobe.
- i_cpu_out_data  in  8  OUTBOX head.
- i_cpu_out_empty  in  1  OUTBOX empty.
- o_cpu_dmp_chip_select  out  3  dump component select.
- o_cpu_dmp_fifo_pos  out  5  dump position.
- i_cpu_dmp_data  in  8  dump value.
- i_cpu_dmp_valid  in  1  dump position valid.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; FSM = IDLE; egress register empty.
- Ingress path:
  - Combinational: o_h_ready = ~i_cpu_in_full; o_cpu_in_wr = i_h_valid & ~i_cpu_in_full; o_cpu_in_data = i_h_data.
  - Independent of dump activity.
  - While i_rst_n is low, o_h_ready = 0.
- Egress register: one entry (data, tag, last, valid).
  - Transfer occurs on the edge where o_h_valid & i_h_ready; the entry empties unless reloaded the same cycle.
  - Reload in the same cycle as a transfer is not permitted, so throughput is at most one byte per 2 cycles. This lets the OUTBOX flags settle.
- FSM states: IDLE, DSET, DWAIT, DEMIT.
- IDLE:
  - If i_cmd_dump and the egress register is empty: latch sel, pos=0, drive o_cpu_dmp_chip_select=sel, go to DSET, o_busy=1.
  - If i_cmd_dump and the egress register is full: the command is ignored.
  - If i_cmd_dump is high in any non-IDLE state: ignored.
  - Else if ~i_cpu_out_empty and the egress register is empty:
    - Pulse o_cpu_out_rd for exactly 1 cycle.
    - Load {i_cpu_out_data, tag 00, last 0} in that same cycle.
  - A dump request has priority over an OUTBOX pop in the same cycle.
  - OUTBOX is never popped outside IDLE.
- DSET: drive o_cpu_dmp_fifo_pos=pos, load wait counter = DMP_LAT, go to DWAIT.
- DWAIT:
  - Decrement the counter; at 0, sample i_cpu_dmp_data and i_cpu_dmp_valid.
  - Non-FIFO sel (not SEL_INBOX/SEL_OUTBOX): load {data, 01, last 1}, go to DEMIT, done after transfer.
  - FIFO sel, valid=1: load {data, 01, last = (pos == FIFO_DEPTH-1)}.
  - FIFO sel, valid=0, pos=0: load {8'h00, 10, last 1}.
  - FIFO sel, valid=0, pos>0: the previously emitted byte already closed the frame (see lookahead); go to IDLE.
  - Lookahead rule: the last flag must be correct on the byte it rides on. Therefore sample pos+1 validity before releasing a byte.
    - Hold the sampled byte internally.
    - Run DSET/DWAIT for pos+1.
    - Then load the held byte with last = ~valid(pos+1) | (pos == FIFO_DEPTH-1).
    - Only one held byte exists at a time.
- DEMIT:
  - Wait for the egress transfer.
  - If last was 1: go to IDLE, o_busy=0 the next cycle.
  - Otherwise: pos increments (5-bit, no wrap past FIFO_DEPTH-1), continue with the held-byte/lookahead sequence.
- Dump values are not guaranteed stable against concurrent CPU activity; no snapshot is taken.
- Reset mid-dump: FSM to IDLE and the held byte is dropped.
- Egress backpressure: the FSM stalls in DEMIT indefinitely; the dump select/position stays driven.

Test Plan:
- Ingress: i_h_valid=1, bytes 0x05,0x12,0x7F, i_cpu_in_full=0 -> three o_cpu_in_wr pulses with matching data; with i_cpu_in_full=1 -> o_h_ready=0, no writes.
- OUTBOX drain: OUTBOX holds 0x2A,0x81, i_h_ready=1 -> egress 0x2A then 0x81, tag 00, last 0; exactly two o_cpu_out_rd pulses, each 1 cycle, at least 2 cycles apart.
- FIFO dump: INBOX holds 0x01,0x02,0x03; i_cmd_dump, sel=0 -> egress 0x01,0x02,0x03, tag 01, last only on 0x03; o_busy deasserts after; o_cpu_out_rd never asserted during the dump.
- Empty and register dumps: sel=1 with empty OUTBOX -> single byte 0x00, tag 10, last 1; sel=2 with PC=0x17 -> single 0x17, tag 01, last 1.
- Priority/backpressure: i_cmd_dump coincident with non-empty OUTBOX -> dump frame first, OUTBOX drained after; i_h_ready held 0 for 10 cycles mid-dump -> no byte lost or duplicated.
- Reset: assert i_rst_n=0 mid-dump -> all outputs 0 immediately; after release, FSM in IDLE, next command dumps normally.
